// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/grant and shared-mux signals of the round-robin mux arbiter
interface rr_mux_arbiter_if;
    logic [0:3] req;
    logic       done;
    logic [0:3] d;
    logic [0:3] gnt;
    logic [0:1] sel;
    logic       o;
    logic       busy;
    logic       timeout;

    // Requester side: drives requests, release strobe and data lanes.
    modport master (
        output req, done, d,
        input  gnt, sel, o, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, done, d,
        output gnt, sel, o, busy, timeout
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin arbiter with bounded tenure driving a shared 4:1 mux
module rr_mux_arbiter #(
    parameter int MAXHOLD = 15
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [0:3] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       end_done;
    logic       end_drop;
    logic       end_cap;

    // Rotating priority scan: the candidate closest to ptr (k smallest) is
    // visited last so it overrides farther candidates.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Tenure end conditions, only meaningful while in GRANT.
    always_comb begin
        end_done = bus.done;
        end_drop = !bus.req[sel_q];
        end_cap  = (cnt_q == HOLD_LAST);
    end

    // Next-state and next-output computation; sel keeps its last value on release.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                busy_d = 1'b0;
                cnt_d  = 8'd0;
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b1000 >> win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (end_done || end_drop || end_cap) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 2'd1;
                    cnt_d     = 8'd0;
                    // Only a pure hold-limit expiry counts as a forced release.
                    timeout_d = end_cap && !end_done && !end_drop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset wins over everything, including a live tenure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
    assign bus.o       = busy_q & bus.d[sel_q];
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    localparam int MAXHOLD = 15;
    localparam int BOUND   = 3 * (MAXHOLD + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.MAXHOLD(MAXHOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: who owns the mux, how many busy cycles so far, next priority start.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_tmo   = 0;
    int waitc[4];
    bit track[4];

    function automatic logic [0:3] onehot(int i);
        logic [0:3] v;
        v    = 4'b0000;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int prev_owner;
        prev_owner = m_owner;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_sel   = 0;
            m_tmo   = 0;
        end else if (m_owner < 0) begin
            m_tmo = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && bus.req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_held = 1;
            end
        end else begin
            if (bus.done || !bus.req[m_owner] || m_held == MAXHOLD) begin
                m_tmo   = (m_held == MAXHOLD && !bus.done && bus.req[m_owner]) ? 1 : 0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
                m_tmo = 0;
            end
        end
        // Starvation watch: counts from the start of a continuous request to its grant.
        for (int i = 0; i < 4; i++) begin
            if (rst || !bus.req[i]) begin
                waitc[i] = 0;
                track[i] = 1'b1;
            end else if (track[i]) begin
                if (prev_owner < 0 && m_owner == i) begin
                    check($sformatf("starve_bound_req%0d", i), (waitc[i] + 1 <= BOUND) ? 1 : 0, 1);
                    track[i] = 1'b0;
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                end
            end
        end
    endtask

    task automatic compare_model();
        int exp_gnt;
        int exp_o;
        exp_gnt = (m_owner >= 0) ? int'(onehot(m_owner)) : 0;
        exp_o   = (m_owner >= 0) ? int'(bus.d[m_sel]) : 0;
        check("gnt", int'(bus.gnt), exp_gnt);
        check("sel", int'(bus.sel), m_sel);
        check("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
        check("timeout", int'(bus.timeout), m_tmo);
        check("o", int'(bus.o), exp_o);
    endtask

    // One clock: drive inputs, let the edge happen, advance model, check on the falling edge.
    task automatic step(logic r, logic [0:3] rq, logic dn, logic [0:3] dd);
        rst      = r;
        bus.req  = rq;
        bus.done = dn;
        bus.d    = dd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    logic [0:3] cur_req;
    int busy_cnt;

    initial begin
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        bus.d    = 4'b0000;
        @(negedge clk);

        // Reset state
        step(1'b1, 4'b0000, 1'b0, 4'b0000);
        check("lit_reset_gnt", int'(bus.gnt), 0);
        check("lit_reset_busy", int'(bus.busy), 0);
        check("lit_reset_sel", int'(bus.sel), 0);
        check("lit_reset_timeout", int'(bus.timeout), 0);

        // Single requester, mux pass-through and combinational o
        step(1'b0, 4'b0100, 1'b0, 4'b0100);
        check("lit_r1_gnt", int'(bus.gnt), 4);
        check("lit_r1_sel", int'(bus.sel), 1);
        check("lit_r1_o_high", int'(bus.o), 1);
        bus.d = 4'b0000;
        #1;
        check("lit_r1_o_low", int'(bus.o), 0);
        step(1'b0, 4'b0000, 1'b0, 4'b0000);
        check("lit_r1_release", int'(bus.gnt), 0);

        // All requesting, done after each grant: order 0,1,2,3,0 with gaps
        step(1'b1, 4'b0000, 1'b0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, 1'b1, 4'b1010);
            check($sformatf("lit_rr_grant%0d", k), int'(bus.gnt), int'(onehot(k % 4)));
            step(1'b0, 4'b1111, 1'b1, 4'b1010);
            check($sformatf("lit_rr_gap%0d", k), int'(bus.gnt), 0);
        end

        // Hold limit expiry with timeout, then regrant
        step(1'b1, 4'b0000, 1'b0, 4'b0000);
        busy_cnt = 0;
        for (int k = 0; k < MAXHOLD; k++) begin
            step(1'b0, 4'b0010, 1'b0, 4'b0010);
            busy_cnt += int'(bus.busy);
        end
        check("lit_hold_busy_cycles", busy_cnt, 15);
        step(1'b0, 4'b0010, 1'b0, 4'b0010);
        check("lit_hold_gnt_off", int'(bus.gnt), 0);
        check("lit_hold_timeout", int'(bus.timeout), 1);
        step(1'b0, 4'b0010, 1'b0, 4'b0010);
        check("lit_hold_regrant", int'(bus.gnt), 2);
        check("lit_hold_tmo_clear", int'(bus.timeout), 0);

        // done on the last allowed cycle suppresses timeout
        for (int k = 0; k < MAXHOLD - 1; k++) step(1'b0, 4'b0010, 1'b0, 4'b0000);
        check("lit_done_last_busy", int'(bus.busy), 1);
        step(1'b0, 4'b0010, 1'b1, 4'b0000);
        check("lit_done_last_gnt", int'(bus.gnt), 0);
        check("lit_done_last_tmo", int'(bus.timeout), 0);

        // Pointer wraps 3 -> 0
        step(1'b1, 4'b0000, 1'b0, 4'b0000);
        step(1'b0, 4'b0001, 1'b0, 4'b0001);
        check("lit_wrap_owner3", int'(bus.gnt), 1);
        step(1'b0, 4'b1011, 1'b0, 4'b0001);
        step(1'b0, 4'b1011, 1'b1, 4'b0001);
        step(1'b0, 4'b1011, 1'b0, 4'b0001);
        check("lit_wrap_grant0", int'(bus.gnt), 8);

        // Reset mid-tenure aborts without timeout; arbitration restarts at 0
        step(1'b1, 4'b0000, 1'b0, 4'b0000);
        step(1'b0, 4'b0001, 1'b0, 4'b0000);
        check("lit_abort_owner", int'(bus.gnt), 1);
        step(1'b1, 4'b0001, 1'b0, 4'b0000);
        check("lit_abort_gnt", int'(bus.gnt), 0);
        check("lit_abort_busy", int'(bus.busy), 0);
        check("lit_abort_tmo", int'(bus.timeout), 0);
        step(1'b0, 4'b0011, 1'b0, 4'b0000);
        check("lit_abort_regrant2", int'(bus.gnt), 2);

        // Randomized traffic against the model
        cur_req = 4'b0000;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) cur_req[i] = ~cur_req[i];
            end
            step(($urandom_range(0, 299) == 0), cur_req,
                 ($urandom_range(0, 9) == 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
